uart_fb_loader: RTL and testbench
=================================

Name: uart_fb_loader

Overview:
Upstream stage of the VGA framebuffer. Receives a 4-bit-per-pixel image over the FTDI UART (port B) and writes it into the 320x240 pixel video RAM through that RAM's write port. The VGA scan-out stage reads the same RAM and maps each 4-bit index to an RGB565 colour. Lets the host replace the displayed picture at run time without re-synthesis.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer division (868 at defaults)
FB_PIXELS, 76800, pixels per frame (320x240)
ADDR_W, 17, framebuffer address width
HEADER, 8'hA5, frame start byte
TIMEOUT_CYC, 2000000, maximum idle gap between bytes inside a frame, in clk cycles (20 ms)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
ftdi_rx  in  1  UART serial input, asynchronous, idle high
wr_en  out  1  one-cycle framebuffer write strobe; the RAM always accepts it
wr_addr  out  ADDR_W  pixel address, linear, y*320+x
wr_data  out  4  pixel palette index
busy  out  1  high from header acceptance until frame end or abort
frame_done  out  1  one-cycle pulse after the last pixel write
err  out  1  one-cycle pulse on abort (framing error or timeout)

Behaviour:
- Reset: every output is 0. Both rx synchroniser flops reset to 1. FSM goes to IDLE, address counter to 0.
- Reset is asynchronous and may occur mid-frame. Already-written pixels stay in RAM. After reset release the block waits for a new HEADER.
- UART RX (8N1, LSB first):
  - ftdi_rx passes through a 2-flop synchroniser.
  - A falling edge starts the bit counter. The start bit is re-sampled at CLKS_PER_BIT/2; if it reads 1, the edge is treated as a glitch and the receiver returns to idle.
  - Data bits are sampled every CLKS_PER_BIT after the start-bit sample, then the stop bit is sampled.
  - Stop=1 gives a byte_valid pulse with the byte. Stop=0 gives a frame_err pulse instead and no byte.
  - The receiver re-arms immediately after the stop-bit sample, so back-to-back bytes are supported.
- Loader FSM states: IDLE, LOAD, WR_HI, WR_LO.
  - IDLE: a byte equal to HEADER moves to LOAD, clears the address to 0 and sets busy. Any other byte is ignored. frame_err in IDLE is ignored, with no err pulse.
  - LOAD: a byte_valid latches the byte and moves to WR_HI.
  - WR_HI (1 cycle): wr_en=1, wr_data=byte[7:4], wr_addr=addr. Address increments. Moves to WR_LO.
  - WR_LO (1 cycle): wr_en=1, wr_data=byte[3:0], wr_addr=addr. Address increments.
  - After WR_LO, if the pixel just written was at address FB_PIXELS-1: frame_done pulses in the next cycle, busy drops, and the FSM returns to IDLE. Otherwise it returns to LOAD.
- Each byte produces exactly two writes on consecutive cycles. A full frame is FB_PIXELS/2 = 38400 data bytes after the header. Bytes after the last one are treated as IDLE traffic.
- The gap counter clears on every byte_valid and counts while in LOAD.
  - When it reaches TIMEOUT_CYC: err pulses, busy drops, the FSM returns to IDLE, and the address is not written further.
  - A frame_err while busy aborts the same way.
- A HEADER byte received inside LOAD is pixel data, not a restart.
- wr_addr never exceeds FB_PIXELS-1; wrap-around is impossible by construction.
- Latency: the first wr_en occurs 1 cycle after byte_valid. frame_done occurs 1 cycle after the final wr_en.

Decomposition:
- Shared package vga_pkg holds:
  - FB_W=320, FB_H=240, FB_PIXELS, ADDR_W
  - the HEADER constant
  - the loader FSM state enum
- One sub-module, uart_rx, is natural. It contains the synchroniser, the bit timing and the 8N1 deframing. Outputs: byte_valid, byte, frame_err. Parameter: CLKS_PER_BIT.
- Bench override: CLKS_PER_BIT=16 via CLK_HZ/BAUD for speed.

Test Plan:
- UART timing: drive 8'h3C at exactly CLKS_PER_BIT per bit -> byte_valid once with 8'h3C. A 0.3-bit low glitch on ftdi_rx -> no byte_valid.
- Full frame: HEADER then 38400 bytes of 8'h12 -> 76800 wr_en pulses, addresses 0..76799 in order, data alternating 1,2. frame_done exactly once, 1 cycle after the last write. busy low afterwards.
- Idle filtering: bytes 8'h00, 8'hFF, 8'h5A in IDLE -> no wr_en, busy stays 0. A following HEADER -> busy=1.
- Timeout: HEADER and 10 bytes, then silence -> 20 writes (addresses 0..19), err pulse TIMEOUT_CYC cycles after the last byte_valid, busy=0. A new HEADER restarts at address 0.
- Framing error: HEADER, 5 bytes, then a byte whose stop bit is 0 -> err pulse, 10 writes only, FSM in IDLE.
- Reset mid-frame: assert rst_n low after 100 bytes -> all outputs 0 asynchronously. After release, HEADER plus data -> writes start at address 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and state encodings for the VGA framebuffer path.
// The loader and the UART receiver both import this package.
package vga_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int FB_PIXELS = FB_W * FB_H;
  localparam int ADDR_W    = 17;

  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_WR_HI,
    LD_WR_LO
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_fb_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, start-glitch
// rejection and stop-bit check. Emits one-cycle byte_valid or frame_err pulses.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | counting to mid start bit; a high sample there is a glitch
// RX_DATA  | sampling 8 data bits, LSB first, one per bit period
// RX_STOP  | sampling the stop bit; 1 -> byte_valid, 0 -> frame_err
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);
  import vga_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], rx};
    prev_d  = rx_s;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          cnt_d   = CNT_HALF;
        end
      end
      RX_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rx_s) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_DATA;
          cnt_d   = CNT_BIT;
          bit_d   = '0;
        end
      end
      RX_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = CNT_BIT;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Re-arm right at the stop sample so a back-to-back start edge is caught.
          state_d = RX_IDLE;
          valid_d = rx_s;
          ferr_d  = !rx_s;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign rx_byte    = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_fb_loader.sv
// Loads a 4-bit-per-pixel image received over UART into the framebuffer,
// two pixels per byte (high nibble first), framed by a header byte.
//
// state    | meaning
// LD_IDLE  | waiting for the header byte; other traffic ignored
// LD_LOAD  | frame in progress, waiting for the next data byte or timeout
// LD_WR_HI | writing the high nibble of the latched byte
// LD_WR_LO | writing the low nibble; finishes the frame at the last pixel
module uart_fb_loader #(
  parameter int         CLK_HZ      = 100_000_000,
  parameter int         BAUD        = 115_200,
  parameter int         FB_PIXELS   = vga_pkg::FB_PIXELS,
  parameter int         ADDR_W      = vga_pkg::ADDR_W,
  parameter logic [7:0] HEADER      = vga_pkg::HEADER,
  parameter int         TIMEOUT_CYC = 2_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ftdi_rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);
  import vga_pkg::*;

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TMR_W        = $clog2(TIMEOUT_CYC);
  // Loaded two short so the timeout lands exactly TIMEOUT_CYC after byte_valid.
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT_CYC - 2);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FB_PIXELS - 1);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (ftdi_rx),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      tmr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tmr_q   <= tmr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 4'h0;
    if (byte_valid)          tmr_d = TMR_LOAD;
    else if (tmr_q != '0)    tmr_d = tmr_q - TMR_W'(1);
    else                     tmr_d = tmr_q;
    unique case (state_q)
      LD_IDLE: begin
        if (byte_valid && rx_byte == HEADER) begin
          state_d = LD_LOAD;
          addr_d  = '0;
        end
      end
      LD_LOAD: begin
        if (frame_err) begin
          state_d = LD_IDLE;
          err_d   = 1'b1;
        end else if (byte_valid) begin
          state_d = LD_WR_HI;
          data_d  = rx_byte;
        end else if (tmr_q == '0) begin
          state_d = LD_IDLE;
          err_d   = 1'b1;
        end
      end
      LD_WR_HI: begin
        wr_en   = 1'b1;
        wr_data = data_q[7:4];
        addr_d  = addr_q + ADDR_W'(1);
        state_d = LD_WR_LO;
      end
      LD_WR_LO: begin
        wr_en   = 1'b1;
        wr_data = data_q[3:0];
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          done_d  = 1'b1;
          state_d = LD_IDLE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = LD_LOAD;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  assign wr_addr    = addr_q;
  assign busy       = (state_q != LD_IDLE);
  assign frame_done = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_uart_fb_loader.sv
// Directed/randomised bench for uart_fb_loader against a byte-level frame model.
module tb_uart_fb_loader;

  localparam int CPB   = 16;
  localparam int FBP   = 256;
  localparam int TOUT  = 600;
  localparam int AW    = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ftdi_rx;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          busy;
  logic          frame_done;
  logic          err;

  uart_fb_loader #(
    .CLK_HZ     (CPB * 115_200),
    .BAUD       (115_200),
    .FB_PIXELS  (FBP),
    .ADDR_W     (AW),
    .HEADER     (8'hA5),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ftdi_rx   (ftdi_rx),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .frame_done(frame_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every observed event with its cycle stamp.
  logic [AW-1:0] obs_addr[$];
  logic [3:0]    obs_data[$];
  int            obs_cyc[$];
  int            done_cyc[$];
  int            err_cyc[$];
  int            bv_n = 0;
  logic [7:0]    bv_last = 8'h00;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_addr.push_back(wr_addr);
      obs_data.push_back(wr_data);
      obs_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) done_cyc.push_back(cyc);
    if (err === 1'b1)        err_cyc.push_back(cyc);
    if (dut.u_rx.byte_valid === 1'b1) begin
      bv_n    = bv_n + 1;
      bv_last = dut.u_rx.rx_byte;
    end
  end

  // Reference model: frame rules at byte granularity.
  bit         m_busy = 1'b0;
  int         m_addr = 0;
  int         exp_done = 0;
  int         exp_err  = 0;
  int         exp_addr[$];
  logic [3:0] exp_data[$];
  bit         exp_lo[$];
  int         rd = 0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total = total + 1;
    assert (observed === expected) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      if (m_busy) begin
        m_busy  = 1'b0;
        exp_err = exp_err + 1;
      end
    end else if (!m_busy) begin
      if (b == 8'hA5) begin
        m_busy = 1'b1;
        m_addr = 0;
      end
    end else begin
      exp_addr.push_back(m_addr);     exp_data.push_back(b[7:4]); exp_lo.push_back(1'b0);
      exp_addr.push_back(m_addr + 1); exp_data.push_back(b[3:0]); exp_lo.push_back(1'b1);
      m_addr = m_addr + 2;
      if (m_addr == FBP) begin
        m_busy   = 1'b0;
        exp_done = exp_done + 1;
      end
    end
  endtask

  task automatic drive_bit(input logic v);
    ftdi_rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit good);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(good ? 1'b1 : 1'b0);
    if (!good) drive_bit(1'b1);
    model_byte(b, good);
  endtask

  task automatic settle();
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, " wr_count"}, obs_addr.size() - rd, exp_addr.size());
    while (rd < obs_addr.size() && exp_addr.size() != 0) begin
      chk({tag, " wr_addr"}, obs_addr[rd], exp_addr[0]);
      chk({tag, " wr_data"}, obs_data[rd], exp_data[0]);
      if (exp_lo[0] && rd > 0) chk({tag, " wr_pair_gap"}, obs_cyc[rd] - obs_cyc[rd-1], 1);
      void'(exp_addr.pop_front());
      void'(exp_data.pop_front());
      void'(exp_lo.pop_front());
      rd = rd + 1;
    end
    rd = obs_addr.size();
    exp_addr.delete();
    exp_data.delete();
    exp_lo.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " wr_en"},      wr_en, 0);
    chk({tag, " wr_addr"},    wr_addr, 0);
    chk({tag, " wr_data"},    wr_data, 0);
    chk({tag, " busy"},       busy, 0);
    chk({tag, " frame_done"}, frame_done, 0);
    chk({tag, " err"},        err, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int bv0;

    rst_n   = 1'b0;
    ftdi_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Single byte at nominal timing.
    send(8'h3C, 1'b1);
    settle();
    chk("uart byte_valid count", bv_n, 1);
    chk("uart byte value", bv_last, 8'h3C);

    // 0.3-bit low glitch must not start a byte.
    bv0 = bv_n;
    ftdi_rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    ftdi_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    chk("glitch byte_valid count", bv_n, bv0);

    // Idle traffic is ignored; header arms the loader.
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h5A, 1'b1);
    settle();
    check_writes("idle");
    chk("idle busy", busy, 0);
    send(8'hA5, 1'b1);
    settle();
    chk("header busy", busy, 1);

    // Full frame; one data byte equals the header value.
    for (int i = 0; i < FBP / 2; i++) begin
      if (i < 4)       b = 8'h12;
      else if (i == 9) b = 8'hA5;
      else             b = 8'($urandom);
      send(b, 1'b1);
    end
    settle();
    check_writes("frame");
    chk("frame done count", done_cyc.size(), exp_done);
    if (done_cyc.size() != 0 && obs_cyc.size() != 0)
      chk("frame done latency", done_cyc[$] - obs_cyc[$], 1);
    chk("frame busy after", busy, 0);

    send(8'h12, 1'b1);
    settle();
    check_writes("post-frame");
    chk("post-frame busy", busy, 0);

    // Timeout after 10 bytes.
    send(8'hA5, 1'b1);
    for (int i = 0; i < 10; i++) send(8'($urandom), 1'b1);
    settle();
    check_writes("timeout");
    chk("timeout early err", err_cyc.size(), exp_err);
    repeat (TOUT) @(posedge clk);
    #1;
    m_busy  = 1'b0;
    exp_err = exp_err + 1;
    chk("timeout err count", err_cyc.size(), exp_err);
    if (err_cyc.size() != 0 && obs_cyc.size() != 0)
      chk("timeout err latency", err_cyc[$] - obs_cyc[$], TOUT - 2);
    chk("timeout busy", busy, 0);

    // Restart at address 0, then framing error aborts.
    send(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b1);
    send(8'($urandom), 1'b0);
    settle();
    check_writes("framing");
    chk("framing err count", err_cyc.size(), exp_err);
    chk("framing busy", busy, 0);
    send(8'h33, 1'b1);
    settle();
    check_writes("framing idle");
    chk("framing idle busy", busy, 0);

    // Asynchronous reset mid-frame.
    send(8'hA5, 1'b1);
    for (int i = 0; i < 100; i++) send(8'($urandom), 1'b1);
    settle();
    check_writes("pre-reset");
    chk("pre-reset busy", busy, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async reset");
    m_busy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b1);
    settle();
    check_writes("post-reset");
    chk("post-reset busy", busy, 1);
    chk("final done count", done_cyc.size(), exp_done);
    chk("final err count", err_cyc.size(), exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
